// File: rtl/keypad_pkg.sv
// Shared types, defaults and the key-code width helper for the keypad scanner.
package keypad_pkg;

   typedef enum logic [1:0] {
      DRIVE,
      SAMPLE,
      EVAL
   } scan_state_t;

   typedef enum logic [1:0] {
      NONE,
      ONE,
      MULTI
   } scan_class_t;

   localparam int DEF_ROWS           = 4;
   localparam int DEF_COLS           = 4;
   localparam int DEF_SETTLE_CYCLES  = 4;
   localparam int DEF_DEBOUNCE_SCANS = 3;
   localparam int DEF_FIFO_DEPTH     = 4;
   localparam int DEF_REPEAT_SCANS   = 64;

   function automatic int code_width(input int n_keys);
      return (n_keys <= 2) ? 1 : $clog2(n_keys);
   endfunction

endpackage

// File: rtl/keypad_fifo.sv
// First-word-fall-through queue for key events; a push on a full queue without
// a simultaneous pop is dropped and reported with a one-cycle overflow pulse.
module keypad_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic             overflow
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a push on full still lands.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         overflow <= push && full && !do_pop;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: one-hot column drive, synchronised row sampling, whole-scan
// debounce of a single key and a FWFT event queue. KEYPAD_REPEAT_EN adds auto-repeat.
//
// state  | meaning
// DRIVE  | current column driven, settle counter running
// SAMPLE | synced rows captured into the scan image for the current column
// EVAL   | columns released, image classified, debounce/event update
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int ROWS           = DEF_ROWS,
   parameter int COLS           = DEF_COLS,
   parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
   parameter int DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS,
   parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
   parameter int REPEAT_SCANS   = DEF_REPEAT_SCANS,
   localparam int CW            = code_width(ROWS * COLS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            scan_en,
   input  logic [ROWS-1:0] row,
   output logic [COLS-1:0] col,
   output logic            key_valid,
   output logic [CW-1:0]   key_code,
   input  logic            key_ready,
   output logic            key_held,
   output logic            overflow
);

   localparam int NK  = ROWS * COLS;
   localparam int CIW = $clog2(COLS);
   localparam int SW  = $clog2(SETTLE_CYCLES);
   localparam int PW  = $clog2(DEBOUNCE_SCANS + 1);

   if (ROWS < 2 || ROWS > 8 || COLS < 2 || COLS > 8 || SETTLE_CYCLES < 3 ||
       DEBOUNCE_SCANS < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       REPEAT_SCANS < 1) begin : g_bad_param
      $error("keypad_scanner: parameter out of range");
   end

   logic [ROWS-1:0] row_meta;
   logic [ROWS-1:0] row_sync;
   logic            scan_act;
   logic            run;

   scan_state_t     state, state_nxt;
   logic [CIW-1:0]  col_idx, col_idx_nxt;
   logic [SW-1:0]   settle_cnt, settle_nxt;
   logic [NK-1:0]   image, image_nxt;

   scan_class_t     scan_class;
   logic [CW-1:0]   hit_code;

   logic [CW-1:0]   cand, cand_nxt;
   logic            cand_v, cand_v_nxt;
   logic [PW-1:0]   press_cnt, press_nxt;
   logic [PW-1:0]   rel_cnt, rel_nxt;
   logic            reported, reported_nxt;
   logic            push;
   logic            fifo_empty;
   logic            unused_fifo_full;

`ifdef KEYPAD_REPEAT_EN
   localparam int RW = $clog2(REPEAT_SCANS + 1);
   logic [RW-1:0]   rep_cnt, rep_nxt;
   logic [CW-1:0]   held_code, held_code_nxt;
`endif

   // scan_act delays the start by one cycle so col stays 0 while rst is asserted.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_meta <= '0;
         row_sync <= '0;
         scan_act <= 1'b0;
      end else begin
         row_meta <= row;
         row_sync <= row_meta;
         scan_act <= scan_en;
      end
   end

   assign run = scan_en && scan_act;

   always_comb begin
      state_nxt   = state;
      col_idx_nxt = col_idx;
      settle_nxt  = settle_cnt;
      if (!run) begin
         state_nxt   = DRIVE;
         col_idx_nxt = '0;
         settle_nxt  = '0;
      end else begin
         case (state)
            DRIVE: begin
               if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                  state_nxt  = SAMPLE;
                  settle_nxt = '0;
               end else begin
                  settle_nxt = settle_cnt + 1'b1;
               end
            end
            SAMPLE: begin
               if (col_idx == CIW'(COLS - 1)) begin
                  state_nxt = EVAL;
               end else begin
                  state_nxt   = DRIVE;
                  col_idx_nxt = col_idx + 1'b1;
               end
            end
            EVAL: begin
               state_nxt   = DRIVE;
               col_idx_nxt = '0;
            end
            default: state_nxt = DRIVE;
         endcase
      end
   end

   always_comb begin
      col       = '0;
      image_nxt = image;
      for (int c = 0; c < COLS; c++) begin
         if (run && state != EVAL && CIW'(c) == col_idx) col[c] = 1'b1;
      end
      if (!run) begin
         image_nxt = '0;
      end else if (state == SAMPLE) begin
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
               if (CIW'(c) == col_idx) image_nxt[r * COLS + c] = row_sync[r];
            end
         end
      end
   end

   // Population count saturates at two; the lowest set bit gives the code.
   always_comb begin
      logic [1:0] ones;
      ones     = 2'd0;
      hit_code = '0;
      for (int i = 0; i < NK; i++) begin
         if (image[i]) begin
            if (ones == 2'd0) hit_code = CW'(i);
            if (ones != 2'd2) ones = ones + 2'd1;
         end
      end
      case (ones)
         2'd0:    scan_class = NONE;
         2'd1:    scan_class = ONE;
         default: scan_class = MULTI;
      endcase
   end

   always_comb begin
      cand_nxt     = cand;
      cand_v_nxt   = cand_v;
      press_nxt    = press_cnt;
      rel_nxt      = rel_cnt;
      reported_nxt = reported;
      push         = 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_nxt       = rep_cnt;
      held_code_nxt = held_code;
`endif
      if (!run) begin
         cand_nxt     = '0;
         cand_v_nxt   = 1'b0;
         press_nxt    = '0;
         rel_nxt      = '0;
         reported_nxt = 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rep_nxt = '0;
`endif
      end else if (state == EVAL) begin
         case (scan_class)
            NONE: begin
               press_nxt = '0;
               if (rel_cnt != PW'(DEBOUNCE_SCANS)) rel_nxt = rel_cnt + 1'b1;
               if (rel_nxt == PW'(DEBOUNCE_SCANS)) begin
                  reported_nxt = 1'b0;
`ifdef KEYPAD_REPEAT_EN
                  rep_nxt = '0;
`endif
               end
            end
            ONE: begin
               rel_nxt = '0;
               if (cand_v && cand == hit_code) begin
                  if (press_cnt != PW'(DEBOUNCE_SCANS)) press_nxt = press_cnt + 1'b1;
               end else begin
                  cand_nxt   = hit_code;
                  cand_v_nxt = 1'b1;
                  press_nxt  = PW'(1);
               end
               if (!reported && press_nxt == PW'(DEBOUNCE_SCANS)) begin
                  push         = 1'b1;
                  reported_nxt = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                  held_code_nxt = hit_code;
                  rep_nxt       = '0;
               end else if (reported && hit_code == held_code) begin
                  if (rep_cnt == RW'(REPEAT_SCANS - 1)) begin
                     push    = 1'b1;
                     rep_nxt = '0;
                  end else begin
                     rep_nxt = rep_cnt + 1'b1;
                  end
`endif
               end
            end
            MULTI: begin
               press_nxt  = '0;
               rel_nxt    = '0;
               cand_nxt   = '0;
               cand_v_nxt = 1'b0;
`ifdef KEYPAD_REPEAT_EN
               rep_nxt = '0;
`endif
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= DRIVE;
         col_idx    <= '0;
         settle_cnt <= '0;
         image      <= '0;
         cand       <= '0;
         cand_v     <= 1'b0;
         press_cnt  <= '0;
         rel_cnt    <= '0;
         reported   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rep_cnt    <= '0;
         held_code  <= '0;
`endif
      end else begin
         state      <= state_nxt;
         col_idx    <= col_idx_nxt;
         settle_cnt <= settle_nxt;
         image      <= image_nxt;
         cand       <= cand_nxt;
         cand_v     <= cand_v_nxt;
         press_cnt  <= press_nxt;
         rel_cnt    <= rel_nxt;
         reported   <= reported_nxt;
`ifdef KEYPAD_REPEAT_EN
         rep_cnt    <= rep_nxt;
         held_code  <= held_code_nxt;
`endif
      end
   end

   assign key_held  = reported;
   assign key_valid = !fifo_empty;

   // Queue fullness is only observable here through the overflow pulse.
   keypad_fifo #(
      .WIDTH (CW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (hit_code),
      .pop       (key_ready),
      .pop_data  (key_code),
      .full      (unused_fifo_full),
      .empty     (fifo_empty),
      .overflow  (overflow)
   );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a vector table for press/release debounce plus
// hand sequences for reset, column timing, overflow, scan_en drop and auto-repeat.
module tb_keypad_scanner;

   localparam int ROWS = 4;
   localparam int COLS = 4;
`ifdef KEYPAD_REPEAT_EN
   localparam int REP    = 4;
   localparam int EXP_EV = 4;
`else
   localparam int REP    = 64;
   localparam int EXP_EV = 1;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            scan_en;
   logic            key_ready;
   logic [ROWS-1:0] row;
   logic [COLS-1:0] col;
   logic            key_valid;
   logic [3:0]      key_code;
   logic            key_held;
   logic            overflow;
   logic [15:0]     keys;

   int total = 0;
   int bad   = 0;
   int ovf_cnt = 0;
   int ev_cnt  = 0;

   always #5 clk = ~clk;

   keypad_scanner #(
      .ROWS           (ROWS),
      .COLS           (COLS),
      .SETTLE_CYCLES  (4),
      .DEBOUNCE_SCANS (3),
      .FIFO_DEPTH     (4),
      .REPEAT_SCANS   (REP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .scan_en   (scan_en),
      .row       (row),
      .col       (col),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_ready (key_ready),
      .key_held  (key_held),
      .overflow  (overflow)
   );

   // Keypad model: a closed key connects its driven column to its row.
   always_comb begin
      row = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (keys[r * COLS + c] && col[c]) row[r] = 1'b1;
   end

   always @(negedge clk) begin
      if (overflow) ovf_cnt++;
      if (key_valid && key_ready) ev_cnt++;
   end

   typedef struct {
      logic [15:0] keys;
      int          scans;
      logic        held;
      logic        valid;
      logic [3:0]  code;
      logic        pop;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Advance from inside a scan to the first cycle of the next one (after EVAL).
   task automatic scan_boundary();
      int n;
      n = 0;
      while (col != '0 && n < 64) begin @(negedge clk); n++; end
      while (col == '0 && n < 64) begin @(negedge clk); n++; end
      if (n >= 64) begin
         total++;
         bad++;
         $display("FAIL scan_timeout actual=%0d cycles required<64", n);
      end
   endtask

   task automatic scans(input int n);
      for (int i = 0; i < n; i++) scan_boundary();
   endtask

   task automatic pop_one();
      key_ready = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
   endtask

   function automatic logic [3:0] exp_col(input int i);
      int p;
      p = i % 21;
      if (p == 20) return 4'd0;
      return 4'(1 << (p / 5));
   endfunction

   initial begin
      int ovf_base;
      int ev_base;
      logic [3:0] codes [5];

      vecs[0]  = '{16'h0000, 2, 1'b0, 1'b0, 4'd0,  1'b0};
      vecs[1]  = '{16'h0200, 2, 1'b0, 1'b0, 4'd0,  1'b0};
      vecs[2]  = '{16'h0200, 1, 1'b1, 1'b1, 4'd9,  1'b1};
      vecs[3]  = '{16'h0200, 2, 1'b1, 1'b0, 4'd0,  1'b0};
      vecs[4]  = '{16'h0000, 2, 1'b1, 1'b0, 4'd0,  1'b0};
      vecs[5]  = '{16'h0000, 1, 1'b0, 1'b0, 4'd0,  1'b0};
      vecs[6]  = '{16'h0021, 4, 1'b0, 1'b0, 4'd0,  1'b0};
      vecs[7]  = '{16'h0001, 2, 1'b0, 1'b0, 4'd0,  1'b0};
      vecs[8]  = '{16'h0001, 1, 1'b1, 1'b1, 4'd0,  1'b1};
      vecs[9]  = '{16'h0000, 3, 1'b0, 1'b0, 4'd0,  1'b0};
      vecs[10] = '{16'h0008, 3, 1'b1, 1'b1, 4'd3,  1'b1};
      vecs[11] = '{16'h1000, 4, 1'b1, 1'b0, 4'd0,  1'b0};
      vecs[12] = '{16'h0000, 3, 1'b0, 1'b0, 4'd0,  1'b0};
      codes[0] = 4'd1; codes[1] = 4'd2; codes[2] = 4'd4; codes[3] = 4'd7; codes[4] = 4'd14;

      rst = 1'b1; scan_en = 1'b1; key_ready = 1'b0; keys = '0;
      repeat (3) @(negedge clk);
      check("rst_col", 16'(col), 16'h0);
      check("rst_valid", 16'(key_valid), 16'h0);
      check("rst_code", 16'(key_code), 16'h0);
      check("rst_held", 16'(key_held), 16'h0);
      check("rst_ovf", 16'(overflow), 16'h0);

      rst = 1'b0;
      for (int i = 0; i <= 42; i++) begin
         @(negedge clk);
         check($sformatf("col_cyc%0d", i), 16'(col), 16'(exp_col(i)));
      end
      check("idle_valid", 16'(key_valid), 16'h0);

      for (int i = 0; i < 13; i++) begin
         keys = vecs[i].keys;
         scans(vecs[i].scans);
         check($sformatf("vec%0d_held", i), 16'(key_held), 16'(vecs[i].held));
         check($sformatf("vec%0d_valid", i), 16'(key_valid), 16'(vecs[i].valid));
         if (vecs[i].valid) check($sformatf("vec%0d_code", i), 16'(key_code), 16'(vecs[i].code));
         if (vecs[i].pop) pop_one();
      end

      // scan_en dropped during the third debounce scan discards progress
      keys = 16'h0040;
      scans(2);
      repeat (8) @(negedge clk);
      scan_en = 1'b0;
      @(negedge clk);
      check("dis_col", 16'(col), 16'h0);
      repeat (20) @(negedge clk);
      check("dis_valid", 16'(key_valid), 16'h0);
      check("dis_held", 16'(key_held), 16'h0);
      scan_en = 1'b1;
      @(negedge clk);
      check("reen_col", 16'(col), 16'h1);
      scans(2);
      check("reen_early_valid", 16'(key_valid), 16'h0);
      scans(1);
      check("reen_valid", 16'(key_valid), 16'h1);
      check("reen_code", 16'(key_code), 16'd6);
      pop_one();
      keys = '0;
      scans(3);
      check("reen_release", 16'(key_held), 16'h0);

      // five presses against a stalled consumer
      ovf_base = ovf_cnt;
      check("no_ovf_yet", 16'(ovf_cnt), 16'h0);
      for (int k = 0; k < 5; k++) begin
         keys = 16'h1 << codes[k];
         scans(3);
         keys = '0;
         scans(3);
      end
      check("ovf_pulses", 16'(ovf_cnt - ovf_base), 16'h1);
      check("full_valid", 16'(key_valid), 16'h1);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("drain%0d_code", k), 16'(key_code), 16'(codes[k]));
         pop_one();
      end
      check("drained_valid", 16'(key_valid), 16'h0);

      // reset mid-debounce discards queued events and the reported key
      scan_boundary();
      keys = 16'h0400;
      scans(3);
      check("pre_rst_valid", 16'(key_valid), 16'h1);
      check("pre_rst_code", 16'(key_code), 16'd10);
      keys = 16'h0800;
      scans(2);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_valid", 16'(key_valid), 16'h0);
      check("mid_rst_held", 16'(key_held), 16'h0);
      check("mid_rst_col", 16'(col), 16'h0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_col", 16'(col), 16'h1);
      scans(2);
      check("post_rst_early", 16'(key_valid), 16'h0);
      scans(1);
      check("post_rst_valid", 16'(key_valid), 16'h1);
      check("post_rst_code", 16'(key_code), 16'd11);
      pop_one();
      keys = '0;
      scans(3);

      // long hold: single event, or periodic repeats when enabled
      ev_base = ev_cnt;
      key_ready = 1'b1;
      keys = 16'h8000;
      scans(15);
      keys = '0;
      scans(3);
      key_ready = 1'b0;
      check("hold_events", 16'(ev_cnt - ev_base), 16'(EXP_EV));
      check("hold_release", 16'(key_held), 16'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised matrix-keypad scanner for the security controller: drives columns one-hot, samples rows through a synchroniser, debounces a single pressed key over whole scans, and queues key codes into a small FIFO read via valid/ready. It sits between the physical keypad pins and the code-entry/arming logic, replacing direct row/column handling with clean one-per-press key events.

## Interface
- ROWS, 4, number of keypad rows (2..8)
- COLS, 4, number of keypad columns (2..8)
- SETTLE_CYCLES, 4, cycles a column is driven before its rows are sampled (>= 3)
- DEBOUNCE_SCANS, 3, consecutive identical scans required to accept a press or a release (>= 1)
- FIFO_DEPTH, 4, key-event queue depth (power of two, >= 2)
- REPEAT_SCANS, 64, scans between auto-repeat events (only with KEYPAD_REPEAT_EN)

- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- scan_en  input  1  1 = scanning enabled
- row  input  ROWS  raw row lines, 1 = key closed in the driven column, asynchronous
- col  output  COLS  one-hot column drive, 1 = driven
- key_valid  output  1  FIFO non-empty
- key_code  output  CW = $clog2(ROWS*COLS)  head key code, r*COLS + c
- key_ready  input  1  consumer accepts head when key_valid & key_ready
- key_held  output  1  debounced key currently accepted and held
- overflow  output  1  one-cycle pulse when an event is dropped on full FIFO

## Operation
- row passes a 2-FF synchroniser; all sampling uses the synchronised value.
- FSM: DRIVE -> SAMPLE -> (next column DRIVE | EVAL after column COLS-1) -> DRIVE column 0.
- DRIVE: col = one-hot of current column, settle counter counts SETTLE_CYCLES cycles.
- SAMPLE: one cycle, writes synced row into scan image bits for current column; col stays driven.
- EVAL: one cycle, col = 0; classifies image: NONE (all zero), ONE (exactly one bit, code r*COLS+c), MULTI (two or more bits).
- Debounce: candidate register plus stable counter. ONE matching candidate -> counter++ (saturate at DEBOUNCE_SCANS); ONE different -> candidate = new, counter = 1; NONE -> release counter++, press counter = 0; MULTI -> press counter = 0, candidate cleared, no event, key_held unchanged.
- Accept: press counter reaches DEBOUNCE_SCANS and key not already reported -> push code, set reported, key_held = 1.
- Release: DEBOUNCE_SCANS consecutive NONE scans -> clear reported, key_held = 0. A different single key while reported is ignored until release.
- FIFO first-word-fall-through: key_code = head whenever key_valid. Pop on key_valid & key_ready.
- Push on full without simultaneous pop -> event dropped, overflow pulses 1 cycle. Push and pop same cycle on full -> both take effect, no overflow.
- scan_en = 0: col = 0, FSM forced to DRIVE column 0, settle counter, image, candidate, counters, reported, key_held cleared. FIFO contents retained and still drainable.
- key_code is don't-care when key_valid = 0; drive 0.

## Timing
- Reset values: col = 0, key_valid = 0, key_code = 0, key_held = 0, overflow = 0; FSM DRIVE column 0, FIFO empty, all counters 0.
- First cycle after rst release with scan_en = 1: col = 1 (column 0).
- Scan period = COLS*(SETTLE_CYCLES+1) + 1 cycles (21 with defaults).
- Push occurs in EVAL; key_valid and key_held rise the following cycle.
- Press-to-key_valid latency: DEBOUNCE_SCANS scans after first scan seeing the key (3 scans, 63 cycles with defaults, plus 0..1 partial scan).
- Reset mid-scan or mid-debounce: all state cleared next edge, pending FIFO events discarded.
- key_valid drops the cycle after popping the last entry.

## Configuration
- KEYPAD_REPEAT_EN defined: while reported key stays ONE and matching, a repeat counter counts EVALs; every REPEAT_SCANS scans pushes the same code again (overflow rules apply). Counter cleared on release, MULTI, or scan_en = 0.
- Not defined: exactly one event per press; REPEAT_SCANS unused, no repeat counter synthesised.

## Structure
- keypad_pkg: scan_state_t enum (DRIVE, SAMPLE, EVAL), scan_class_t enum (NONE, ONE, MULTI), code-width function, default parameter constants.
- Sub-module keypad_fifo: parametrised FWFT FIFO (width CW, depth FIFO_DEPTH) with push, pop, full, empty, overflow pulse.

## Test plan
- Reset then scan_en = 1, no keys -> col cycles 1,2,4,8 each driven 5 cycles then 0 for 1; key_valid stays 0.
- Hold row[2] during column 1 driven (key 9) for 5 scans -> exactly one key_valid with key_code = 9, key_held = 1; release 3 scans -> key_held = 0.
- Keys 0 and 5 held together -> no event, key_held = 0; release 5, hold 0 -> one event code 0.
- key_ready = 0, press/release 5 distinct keys -> 4 queued, overflow pulses once on 5th; drain returns first 4 codes in order.
- Key held, scan_en dropped mid-debounce (scan 2) -> col = 0, no event; re-enable and hold 3 scans -> one event.
- KEYPAD_REPEAT_EN, REPEAT_SCANS = 4, key 15 held 15 scans -> events at scans 3, 7, 11, 15; without macro -> single event.
